// File: rtl/mp_adder_ctrl_pkg.sv
// Shared definitions for the multi-precision adder sequencer.
package mp_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the word index counter: clog2 of the word count, never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned num_words);
        if (num_words <= 1) begin
            return 1;
        end
        return $clog2(num_words);
    endfunction

endpackage

// File: rtl/rca_adder.sv
// Narrow ripple-carry adder built from a chain of full-adder cells.
module rca_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    logic [WIDTH:0] carry;

    assign carry[0] = ci;

    // One full-adder cell per bit; carry ripples from bit 0 upward.
    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign sum[g]     = a[g] ^ b[g] ^ carry[g];
        assign carry[g+1] = (a[g] & b[g]) | (carry[g] & (a[g] ^ b[g]));
    end

    assign co = carry[WIDTH];

endmodule

// File: rtl/mp_adder_ctrl.sv
// Multi-precision add/subtract sequencer: one word per clock through a shared adder.
module mp_adder_ctrl
    import mp_adder_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            sub,
    input  logic                            ci,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] a,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] b,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_WIDTH*NUM_WORDS-1:0] sum,
    output logic                            co
);

    localparam int unsigned IDX_W = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    carry;
    logic [DATA_WIDTH-1:0]   op_a      [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   op_b      [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   sum_words [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   add_sum;
    logic                    add_co;

    // Shared narrow adder, fed by the current word of each captured operand.
    rca_adder #(
        .WIDTH (DATA_WIDTH)
    ) u_rca (
        .a   (op_a[idx]),
        .b   (op_b[idx]),
        .ci  (carry),
        .sum (add_sum),
        .co  (add_co)
    );

    // Result words are registers; expose them as one flat bus.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_sum
        assign sum[g*DATA_WIDTH +: DATA_WIDTH] = sum_words[g];
    end

    // Sequencer: capture operands, walk words LSW first, then pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            co    <= 1'b0;
            for (int w = 0; w < NUM_WORDS; w++) begin
                op_a[w]      <= '0;
                op_b[w]      <= '0;
                sum_words[w] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so b is inverted on capture and ci forced high.
                        for (int w = 0; w < NUM_WORDS; w++) begin
                            op_a[w] <= a[w*DATA_WIDTH +: DATA_WIDTH];
                            op_b[w] <= sub ? ~b[w*DATA_WIDTH +: DATA_WIDTH]
                                           :  b[w*DATA_WIDTH +: DATA_WIDTH];
                        end
                        carry <= sub ? 1'b1 : ci;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_words[idx] <= add_sum;
                    carry          <= add_co;
                    if (idx == LAST_IDX) begin
                        // Final carry is published together with the done pulse.
                        co    <= add_co;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_adder_ctrl.sv
// Directed self-checking bench for mp_adder_ctrl (8-bit words, 4 words and 1 word builds).
module tb_mp_adder_ctrl;

    logic        clk;
    logic        rst;

    logic        start, sub, ci;
    logic [31:0] a, b;
    logic        busy, done, co;
    logic [31:0] sum;

    logic        start1, sub1, ci1;
    logic [7:0]  a1, b1;
    logic        busy1, done1, co1;
    logic [7:0]  sum1;

    int checks;
    int errors;

    mp_adder_ctrl #(
        .DATA_WIDTH (8),
        .NUM_WORDS  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .ci    (ci),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    mp_adder_ctrl #(
        .DATA_WIDTH (8),
        .NUM_WORDS  (1)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .sub   (sub1),
        .ci    (ci1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .co    (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full 4-word operation started at the current negedge; inputs scrambled once captured.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv,
                          input logic [31:0] es, input logic ec);
        a = av; b = bv; sub = sv; ci = cv; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            ci = ~ci;
            a  = ~a;
            b  = b + 32'h0101_0101;
            check({tag, "_busy"}, 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
            check({tag, "_done"}, 32'(done), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                check({tag, "_sum"}, sum, es);
                check({tag, "_co"}, 32'(co), 32'(ec));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        start1 = 1'b0; sub1 = 1'b0; ci1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_sum1", 32'(sum1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add, carry across a word boundary
        run_op("s1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
        // Carry ripples through every word
        run_op("s2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        // Carry-in only
        run_op("s2b", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
        // Subtraction, ci ignored
        run_op("s3a", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1);
        run_op("s3b", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);

        // Start held high, operands changed during RUN
        a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b0; ci = 1'b0; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2) begin
                a = 32'h1000_0000;
                b = 32'h0100_0000;
            end
            if (k == 7) start = 1'b0;
            check("s4_done", 32'(done), (k == 5 || k == 11) ? 32'd1 : 32'd0);
            if (k == 5) check("s4_sum_first", sum, 32'h0000_0030);
            if (k == 6) check("s4_busy_gap", 32'(busy), 32'd0);
            if (k == 7) check("s4_busy_next", 32'(busy), 32'd1);
            if (k == 11) check("s4_sum_second", sum, 32'h1100_0000);
        end
        @(negedge clk);

        // Leave a nonzero result and co=1 so the reset clearing is visible
        run_op("s5pre", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001, 1'b1);

        // Reset mid-RUN discards the operation
        a = 32'h0102_0304; b = 32'h0101_0101; sub = 1'b0; ci = 1'b0; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                check("s5_busy", 32'(busy), 32'd0);
                check("s5_done", 32'(done), 32'd0);
                check("s5_sum", sum, 32'd0);
                check("s5_co", 32'(co), 32'd0);
            end
            if (k > 4) check("s5_no_done", 32'(done), 32'd0);
        end
        run_op("s5_again", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);

        // Single-word build: start together with rst is ignored
        rst = 1'b1; start1 = 1'b1; start = 1'b1;
        a1 = 8'h55; b1 = 8'h11;
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0; start = 1'b0;
        check("s6_rst_busy1", 32'(busy1), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("s6_rst_done1", 32'(done1), 32'd0);
        check("s6_rst_sum1", 32'(sum1), 32'd0);

        // Single-word add completes at T+2
        a1 = 8'hF0; b1 = 8'h20; sub1 = 1'b0; ci1 = 1'b0; start1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start1 = 1'b0;
            a1 = 8'h00;
            check("s6_busy1", 32'(busy1), (k <= 2) ? 32'd1 : 32'd0);
            check("s6_done1", 32'(done1), (k == 2) ? 32'd1 : 32'd0);
            if (k == 2) begin
                check("s6_sum1", 32'(sum1), 32'h0000_0010);
                check("s6_co1", 32'(co1), 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
